// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the debounced button input block.
package btn_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } btn_state_e;

  localparam int DEF_N_BTN       = 4;
  localparam int DEF_DB_CYCLES   = 500_000;
  localparam int DEF_LONG_CYCLES = 50_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and, when BTN_LONG_PRESS_EN
// is defined, a saturating hold timer that emits a single long-press pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef BTN_LONG_PRESS_EN
  , parameter int LONG_CYCLES = DEF_LONG_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
`ifdef BTN_LONG_PRESS_EN
  , output logic long_o
`endif
);

  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  btn_state_e      state_q;
  logic [DB_W-1:0] cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;

  // Two-stage synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM; level and pulses are registered alongside the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        UP: begin
          if (sync2_q) begin
            state_q <= WAIT_DOWN;
            cnt_q   <= '0;
          end
        end
        WAIT_DOWN: begin
          if (!sync2_q) begin
            state_q <= UP;
          end else if (cnt_q == DB_LAST) begin
            state_q <= DOWN;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end
        DOWN: begin
          if (!sync2_q) begin
            state_q <= WAIT_UP;
            cnt_q   <= '0;
          end
        end
        WAIT_UP: begin
          if (sync2_q) begin
            state_q <= DOWN;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= UP;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end
        default: begin
          state_q <= UP;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int                LONG_W    = $clog2(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic              enter_down_s;
  logic [LONG_W-1:0] hold_q;
  logic              long_done_q;
  logic              long_q;

  assign enter_down_s = (state_q == WAIT_DOWN) && sync2_q && (cnt_q == DB_LAST);

  // Hold timer: restarts on each accepted press, counts only while stable DOWN,
  // and saturates so the long pulse fires once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (enter_down_s) begin
        hold_q      <= '0;
        long_done_q <= 1'b0;
      end else if (state_q == DOWN) begin
        if (hold_q == LONG_LAST) begin
          if (!long_done_q) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end
        end else begin
          hold_q <= hold_q + LONG_W'(1);
        end
      end
    end
  end

  assign long_o = long_q;
`endif

endmodule

// File: rtl/btn_input.sv
// Multi-channel debounced button input, one btn_debounce_ch per channel.
// Define BTN_LONG_PRESS_EN to add the btn_long output and per-channel hold timers.
module btn_input
  import btn_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
`ifdef BTN_LONG_PRESS_EN
  , output logic [N_BTN-1:0] btn_long
`endif
);

  if ((N_BTN < 1) || (N_BTN > 8) || (DB_CYCLES < 2) || (LONG_CYCLES <= DB_CYCLES)) begin : g_bad_cfg
    $error("btn_input: invalid N_BTN / DB_CYCLES / LONG_CYCLES combination");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES)
`ifdef BTN_LONG_PRESS_EN
      , .LONG_CYCLES (LONG_CYCLES)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn_in[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
`ifdef BTN_LONG_PRESS_EN
      , .long_o    (btn_long[i])
`endif
    );
  end

endmodule

// File: tb/tb_btn_input.sv
// Self-checking bench for btn_input: directed scenarios plus random bouncing
// inputs checked every cycle against a run-length reference model.
module tb_btn_input;

  localparam int N    = 4;
  localparam int DB   = 16;
  localparam int LONG = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
`ifdef BTN_LONG_PRESS_EN
  logic [N-1:0] btn_long;
`endif

  always #5 clk = ~clk;

  btn_input #(
    .N_BTN       (N),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
`ifdef BTN_LONG_PRESS_EN
    , .btn_long    (btn_long)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two-sample input delay, then a level flips once the
  // delayed input has disagreed with it for DB+1 consecutive cycles.
  logic [N-1:0] p1_m, p2_m, level_m, press_m, rel_m, long_m;
  int           run_m  [N];
  int           hold_m [N];
  bit           done_m [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    press_m = '0;
    rel_m   = '0;
    long_m  = '0;
    if (rst) begin
      p1_m    = '0;
      p2_m    = '0;
      level_m = '0;
      for (int i = 0; i < N; i++) begin
        run_m[i]  = 0;
        hold_m[i] = 0;
        done_m[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        logic s;
        s = p2_m[i];
        // Held down and not currently re-qualifying: hold time advances.
        if (level_m[i] && run_m[i] == 0) begin
          if (hold_m[i] == LONG - 1) begin
            if (!done_m[i]) begin
              long_m[i] = 1'b1;
              done_m[i] = 1'b1;
            end
          end else begin
            hold_m[i]++;
          end
        end
        if (s != level_m[i]) begin
          run_m[i]++;
          if (run_m[i] == DB + 1) begin
            level_m[i] = s;
            run_m[i]   = 0;
            if (s) begin
              press_m[i] = 1'b1;
              hold_m[i]  = 0;
              done_m[i]  = 1'b0;
            end else begin
              rel_m[i] = 1'b1;
            end
          end
        end else begin
          run_m[i] = 0;
        end
      end
      p2_m = p1_m;
      p1_m = btn_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("level", 32'(btn_level), 32'(level_m));
    check_eq("press", 32'(btn_press), 32'(press_m));
    check_eq("release", 32'(btn_release), 32'(rel_m));
    check_eq("press_rel_excl", 32'(btn_press & btn_release), 32'(0));
`ifdef BTN_LONG_PRESS_EN
    check_eq("long", 32'(btn_long), 32'(long_m));
`endif
  endtask

  // Input changed just before this call; pulse expected on the 19th edge (k+2+DB).
  task automatic expect_pulse(input string tag, input logic [N-1:0] mask, input bit is_press);
    for (int j = 1; j <= DB + 3; j++) begin
      step();
      if (j < DB + 3) begin
        check_eq({tag, "_quiet"}, 32'(is_press ? btn_press : btn_release), 32'(0));
      end else begin
        check_eq({tag, "_pulse"}, 32'(is_press ? btn_press : btn_release), 32'(mask));
        check_eq({tag, "_other"}, 32'(is_press ? btn_release : btn_press), 32'(0));
        check_eq({tag, "_lvl"}, 32'(btn_level & mask), 32'(is_press ? mask : 4'b0000));
      end
    end
    step();
    check_eq({tag, "_one_cycle"}, 32'(btn_press | btn_release), 32'(0));
  endtask

  int left_r [N];

  initial begin
    rst    = 1'b1;
    btn_in = 4'b0000;
    for (int i = 0; i < N; i++) begin
      run_m[i]  = 0;
      hold_m[i] = 0;
      done_m[i] = 1'b0;
    end
    repeat (3) step();
    check_eq("rst_level", 32'(btn_level), 32'(0));
    check_eq("rst_press", 32'(btn_press), 32'(0));
    rst = 1'b0;
    repeat (4) step();

    // Clean press on channel 0, held long enough for a long press.
    btn_in[0] = 1'b1;
    expect_pulse("clean_press", 4'b0001, 1'b1);
    for (int j = 2; j <= LONG; j++) begin
      step();
`ifdef BTN_LONG_PRESS_EN
      check_eq("long_at_64", 32'(btn_long), 32'(j == LONG ? 4'b0001 : 4'b0000));
`endif
    end
    for (int j = 0; j < 120; j++) begin
      step();
`ifdef BTN_LONG_PRESS_EN
      check_eq("long_no_repeat", 32'(btn_long), 32'(0));
`endif
    end

    // Release after press.
    btn_in[0] = 1'b0;
    expect_pulse("release", 4'b0001, 1'b0);
    repeat (5) step();

    // Bounce on channel 1: high 5, low 3, then high and held.
    btn_in[1] = 1'b1;
    repeat (5) begin
      step();
      check_eq("bounce_quiet", 32'(btn_press), 32'(0));
    end
    btn_in[1] = 1'b0;
    repeat (3) begin
      step();
      check_eq("bounce_quiet", 32'(btn_press), 32'(0));
    end
    btn_in[1] = 1'b1;
    expect_pulse("bounce_press", 4'b0010, 1'b1);
    btn_in[1] = 1'b0;
    repeat (40) step();

    // Reset 8 cycles into a press on channel 2 that stays high.
    btn_in[2] = 1'b1;
    repeat (8) begin
      step();
      check_eq("rst_mid_quiet", 32'(btn_press), 32'(0));
    end
    rst = 1'b1;
    step();
    check_eq("rst_mid_cleared", 32'(btn_press | btn_level), 32'(0));
    rst = 1'b0;
    expect_pulse("rst_fresh_press", 4'b0100, 1'b1);
    btn_in[2] = 1'b0;
    repeat (40) step();

    // Simultaneous press on channels 1 and 3.
    btn_in = 4'b1010;
    expect_pulse("simul_press", 4'b1010, 1'b1);
    btn_in = 4'b0000;
    expect_pulse("simul_release", 4'b1010, 1'b0);

    // Random bouncing inputs with occasional resets.
    for (int i = 0; i < N; i++) left_r[i] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        left_r[i]--;
        if (left_r[i] <= 0) begin
          btn_in[i] = ~btn_in[i];
          left_r[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 30);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
